// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read addresses/data, write port, clear request and busy.
// Master drives requests (decode/writeback side), slave is the register file.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
);
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  clr_req;
   logic                  busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, clr_req,
      input  rd_data, busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
      output rd_data, busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads and a one-entry-per-cycle clear sequencer.
// Define REGFILE_BYPASS_EN for write-first same-edge read/write; default build is read-first.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst_n,
   regfile_mp_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                r_state;
   logic [ADDR_W-1:0]     r_clr_cnt;
   logic                  r_busy;
   logic [NRD*DATA_W-1:0] r_rd_data;
   logic [DATA_W-1:0]     r_mem [DEPTH];

   logic [ADDR_W-1:0]     w_ra [NRD];
   logic [NRD*DATA_W-1:0] w_rd_next;
   logic                  w_wr_ok;

   always_comb begin
      for (int unsigned i = 0; i < NRD; i++) begin
         w_ra[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      w_wr_ok = bus.wr_en && (r_state == S_IDLE) &&
                !((ZERO_REG != 0) && (bus.wr_addr == '0));
   end

   // Entry 0 is forced to zero ahead of the bypass mux so it wins even on a same-edge write.
   always_comb begin
      w_rd_next = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         if ((ZERO_REG != 0) && (w_ra[i] == '0)) begin
            w_rd_next[i*DATA_W +: DATA_W] = '0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (bus.wr_en && (w_ra[i] == bus.wr_addr)) begin
            w_rd_next[i*DATA_W +: DATA_W] = bus.wr_data;
         end
`endif
         else begin
            w_rd_next[i*DATA_W +: DATA_W] = r_mem[w_ra[i]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
         r_busy    <= 1'b1;
         r_rd_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rd_data <= w_rd_next;
               if (bus.clr_req) begin
                  r_state   <= S_CLEAR;
                  r_clr_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_rd_data <= '0;
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == '1) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_CLEAR;
               r_clr_cnt <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage carries no reset; the clear sequencer defines its contents after reset.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_ok) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.rd_data = r_rd_data;
   assign bus.busy    = r_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file. It is the next-generation CPU register file: write enable, configurable width, depth and read-port count, optional hardwired zero register, and a hardware clear sequencer. It sits between the decode stage (read addresses) and writeback (write port). Reads are registered with one-cycle latency. All storage updates occur on the rising edge of clk.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary storage

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  packed registered read data; port i uses bits [i*DATA_W +: DATA_W]
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr_req  in  1  single-cycle request to clear all entries
busy  out  1  high while the clear sequencer runs

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data is 0.
  - FSM goes to CLEAR with clr_cnt = 0.
  - busy is 1.
  - Storage contents are don't-care until the clear completes.
- FSM states:
  - IDLE: normal operation.
  - CLEAR: one entry is zeroed per cycle at address clr_cnt, then clr_cnt increments.
- FSM transitions:
  - IDLE -> CLEAR when clr_req = 1 at a rising edge; clr_cnt loads 0.
  - CLEAR -> IDLE on the edge that zeroes entry DEPTH-1; busy falls in the following cycle.
  - A full clear occupies exactly DEPTH cycles of busy = 1.
  - clr_req during CLEAR is ignored; the sequence does not restart.
- During CLEAR:
  - wr_en is ignored (write dropped).
  - rd_data registers load 0 every cycle.
- Read path (IDLE):
  - At each rising edge, rd_data[i] <= mem[rd_addr[i]].
  - Data is visible one cycle after the address is presented.
  - rd_data holds its value between edges.
- Write path (IDLE):
  - wr_en = 1 at a rising edge sets mem[wr_addr] <= wr_data.
  - wr_en = 0 leaves memory unchanged.
- Same-edge read and write to the same address: governed by REGFILE_BYPASS_EN (see Optional Feature).
- ZERO_REG = 1:
  - Writes to address 0 are dropped.
  - Reads of address 0 always return 0, including under bypass.
- Reset asserted mid-CLEAR or mid-operation: the clear restarts from entry 0 after rst_n rises.
- Multiple read ports may address the same entry; each returns identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wr_en = 1, the FSM is in IDLE, and rd_addr[i] == wr_addr (not address 0 when ZERO_REG = 1), rd_data[i] loads wr_data on that edge (write-first).
  - This is independent per port.
- Undefined:
  - rd_data[i] loads the pre-write contents (read-first).
  - The new value is visible on the next read.
- All other behaviour is identical in both builds.

Test Plan:
- Reset clear: pulse rst_n low, release; busy stays 1 for exactly 32 cycles then 0. Read all 32 addresses -> rd_data = 0 each.
- Basic write/read: write 0x0000F0F0 to addr 2; next cycle read port0 addr 2 -> 0x0000F0F0 one cycle later. Port1 addr 2 simultaneously returns the same value.
- Zero register: write 0xDEADBEEF to addr 0; read addr 0 -> 0x00000000 (ZERO_REG = 1). With ZERO_REG = 0 the read returns 0xDEADBEEF.
- Bypass: addr 5 holds 0x11111111; on the same edge write 0x22222222 to addr 5 and read addr 5. Result is 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; the next read is 0x22222222 in both builds.
- clr_req mid-run:
  - Fill addrs 1..31 with their index, pulse clr_req, and attempt a write of 0xFFFFFFFF to addr 3 while busy.
  - Required: busy high for 32 cycles, and afterwards addr 3 reads 0.
  - A second clr_req at clear cycle 10 does not extend busy.
- Async reset mid-clear: assert rst_n low at clear cycle 7 without a clock edge -> rd_data = 0 and busy = 1 immediately. After release, busy lasts a full 32 cycles.
